gpio_bus_arbiter: RTL and testbench
===================================

Name: gpio_bus_arbiter

Overview:
Shares one GPIO register port between NREQ requesters (e.g. CPU load/store unit, PWM/bit-bang engine) with round-robin arbitration and a req/ack handshake. Sequences each access into the GPIO's clken/rden/wren cycle and returns read data after the GPIO's 1-cycle registered read latency. Filters illegal accesses: reads of write-only registers, writes to the input register, and unmapped addresses.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 32, GPIO data width
AW, 4, GPIO address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_i  in  NREQ  per-requester request; held with stable command until ack
req_we_i  in  NREQ  1 = write, 0 = read
req_addr_i  in  NREQ*AW  packed addresses, requester n at [n*AW +: AW]
req_wdata_i  in  NREQ*WIDTH  packed write data
ack_o  out  NREQ  one-hot, 1-cycle completion pulse
err_o  out  1  valid with ack; access was illegal and not performed
rdata_o  out  WIDTH  read data, valid with ack on reads
busy_o  out  1  high in any state except IDLE
gpio_address  out  AW  to GPIO address
gpio_data  out  WIDTH  to GPIO data
gpio_rden  out  1  to GPIO rden
gpio_wren  out  1  to GPIO wren
gpio_clken  out  1  to GPIO clken
gpio_q  in  WIDTH  from GPIO q; updates at the clk edge ending the read cycle

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high. Reset forces state IDLE and the RR pointer to 0. It clears the captured command, ack_o, err_o, rdata_o and busy_o, and all gpio_* outputs go to 0.
- Address map (AW=4): 0 PDOR, 1 PSOR, 2 PCOR, 3 PTOR are write-only. 4 PDIR is read-only. 5 PDDR is read/write. 6..15 are unmapped.
- Legal access: write to 0,1,2,3,5, or read from 4,5. Every other access is illegal.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_i is high, grant the first requester at or after the RR pointer, circularly.
  - Capture its we, addr and wdata, compute the legal flag, and go to ISSUE.
  - Advance the RR pointer to grant+1 mod NREQ.
  - If no request is pending, stay in IDLE and keep the pointer.
- ISSUE (1 cycle):
  - Legal access: gpio_clken=1, gpio_address=captured addr, gpio_data=captured wdata, gpio_wren=we, gpio_rden=~we.
  - Illegal access: all gpio strobes stay 0.
  - Always go to RESP.
- RESP (1 cycle):
  - ack_o[grant]=1 and err_o=~legal.
  - rdata_o = gpio_q for a legal read, otherwise 0.
  - Go to IDLE.
- Outside RESP: ack_o=0, err_o=0, rdata_o=0. Outside ISSUE: gpio_clken/rden/wren=0, and gpio_address/gpio_data hold their last value.
- gpio_* outputs decode only from registered state and captured command. No combinational path from req_* to gpio_*.
- Latency and throughput:
  - Request seen in IDLE at cycle t gives ISSUE at t+1 and ack at t+2.
  - Throughput is one access per 3 cycles.
- Handshake:
  - A requester updates req_i at the edge that samples ack=1.
  - If req_i is still high in the following IDLE, it is a new transaction, and the RR pointer gives other pending requesters priority first.
- Command changes or req_i dropping during ISSUE/RESP are ignored. The transaction completes from the captured command.
- Simultaneous requests are resolved by RR only. There is no starvation: with all NREQ requesting, each requester is served once every NREQ transactions.
- Reset during ISSUE: the GPIO write may or may not have occurred. No ack is issued. The next cycle is IDLE.

Decomposition:
- gpio_pkg holds:
  - address constants PDOR_ADDR..PDDR_ADDR (0..5);
  - the FSM state enum/localparams;
  - the function is_legal(we, addr).
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, enable. Outputs grant_onehot[N], grant_idx, any. Pointer register lives in rr_arbiter, updated on enable.

Test Plan:
- Single write: req0 we=1 addr=0 wdata=0xA5A5_0000 -> gpio_wren and gpio_clken high exactly 1 cycle, 1 cycle after request. ack_o=01 2 cycles after request, err_o=0.
- Single read: req1 we=0 addr=4, gpio model q=0x0000_1234 -> ack_o=10 with rdata_o=0x0000_1234, err_o=0, gpio_rden 1 cycle.
- Contention: req0 and req1 held high continuously for 6 transactions from reset -> grant order 0,1,0,1,0,1. Acks spaced 3 cycles apart.
- Illegal access: read addr=2, write addr=4, then read addr=9 -> each gets ack with err_o=1 and rdata_o=0. gpio_clken, gpio_wren and gpio_rden never assert.
- Reset mid-op: assert rst during ISSUE of a req0 write -> no ack_o pulse, busy_o=0 next cycle. Next request served is from pointer 0.
- Command change: alter req_addr_i and req_wdata_i during ISSUE -> GPIO sees the originally captured values, and ack goes to the original requester.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO bus arbiter.
//   - GPIO register address constants
//   - arbiter FSM state encoding
//   - is_legal(): access legality check against the GPIO register map
package gpio_pkg;

  localparam int unsigned PDOR_ADDR = 0;  // write-only
  localparam int unsigned PSOR_ADDR = 1;  // write-only
  localparam int unsigned PCOR_ADDR = 2;  // write-only
  localparam int unsigned PTOR_ADDR = 3;  // write-only
  localparam int unsigned PDIR_ADDR = 4;  // read-only
  localparam int unsigned PDDR_ADDR = 5;  // read/write

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Address is passed zero-extended to 32 bits so the check is independent of AW.
  function automatic logic is_legal(input logic we, input logic [31:0] addr);
    if (we) begin
      return (addr <= 32'(PTOR_ADDR)) || (addr == 32'(PDDR_ADDR));
    end
    return (addr == 32'(PDIR_ADDR)) || (addr == 32'(PDDR_ADDR));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant selection with an internal priority pointer.
// Ports:
//   clk, rst        clock, synchronous active-high reset (pointer -> 0)
//   req_i[N]        request vector
//   enable_i        when high and a grant exists, pointer moves to grant+1 mod N
//   grant_onehot_o  one-hot grant, first requester at/after the pointer
//   grant_idx_o     index of the granted requester
//   any_o           at least one request is pending
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_onehot_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int j;
    j              = 0;
    any_o          = 1'b0;
    grant_idx_o    = '0;
    grant_onehot_o = '0;
    // Scan circularly starting at the pointer; the first hit wins.
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!any_o && req_i[IW'(j)]) begin
        any_o       = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
    if (any_o) grant_onehot_o[grant_idx_o] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (enable_i && any_o) begin
      ptr_q <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: shares one GPIO register port between NREQ requesters.
// Round-robin arbitration, req/ack handshake, one access per 3 cycles.
// Illegal accesses (read of write-only, write of PDIR, unmapped) are acked
// with err_o and never reach the GPIO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting; on any request grant, capture command, advance RR
// ST_ISSUE | drive the GPIO clken/rden/wren cycle (legal access only)
// ST_RESP  | ack the granted requester, return gpio_q / err
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i/req_we_i           per-requester request and direction
//   req_addr_i/req_wdata_i   packed per-requester address / write data
//   ack_o, err_o, rdata_o    one-cycle completion, error flag, read data
//   busy_o                   FSM not idle
//   gpio_*                   GPIO register port (gpio_q: registered read data)
module gpio_bus_arbiter
  import gpio_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ-1:0]       req_we_i,
  input  logic [NREQ*AW-1:0]    req_addr_i,
  input  logic [NREQ*WIDTH-1:0] req_wdata_i,
  output logic [NREQ-1:0]       ack_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  busy_o,
  output logic [AW-1:0]         gpio_address,
  output logic [WIDTH-1:0]      gpio_data,
  output logic                  gpio_rden,
  output logic                  gpio_wren,
  output logic                  gpio_clken,
  input  logic [WIDTH-1:0]      gpio_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q;
  logic              we_q;
  logic              legal_q;
  logic [AW-1:0]     gpio_addr_q;
  logic [WIDTH-1:0]  gpio_data_q;

  logic [NREQ-1:0]   arb_onehot;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic              capture;

  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_wdata;
  logic              sel_legal;

  assign capture = (state_q == ST_IDLE) && arb_any;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .enable_i       (state_q == ST_IDLE),
    .grant_onehot_o (arb_onehot),
    .grant_idx_o    (arb_idx),
    .any_o          (arb_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (arb_idx == IW'(n)) begin
        sel_we    = req_we_i[n];
        sel_addr  = req_addr_i[n*AW +: AW];
        sel_wdata = req_wdata_i[n*WIDTH +: WIDTH];
      end
    end
    sel_legal = is_legal(sel_we, 32'(sel_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      we_q        <= 1'b0;
      legal_q     <= 1'b0;
      gpio_addr_q <= '0;
      gpio_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        grant_q <= arb_onehot;
        we_q    <= sel_we;
        legal_q <= sel_legal;
        // GPIO bus lines only move for accesses that will actually be issued.
        if (sel_legal) begin
          gpio_addr_q <= sel_addr;
          gpio_data_q <= sel_wdata;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_o      = '0;
    err_o      = 1'b0;
    rdata_o    = '0;
    gpio_clken = 1'b0;
    gpio_wren  = 1'b0;
    gpio_rden  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (legal_q) begin
          gpio_clken = 1'b1;
          gpio_wren  = we_q;
          gpio_rden  = ~we_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ack_o = grant_q;
        err_o = ~legal_q;
        // gpio_q was registered at the edge that ended ISSUE.
        if (legal_q && !we_q) rdata_o = gpio_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign gpio_address = gpio_addr_q;
  assign gpio_data    = gpio_data_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
module tb_gpio_bus_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int AW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_i;
  logic [NREQ-1:0]       req_we_i;
  logic [NREQ*AW-1:0]    req_addr_i;
  logic [NREQ*WIDTH-1:0] req_wdata_i;
  logic [NREQ-1:0]       ack_o;
  logic                  err_o;
  logic [WIDTH-1:0]      rdata_o;
  logic                  busy_o;
  logic [AW-1:0]         gpio_address;
  logic [WIDTH-1:0]      gpio_data;
  logic                  gpio_rden;
  logic                  gpio_wren;
  logic                  gpio_clken;
  logic [WIDTH-1:0]      gpio_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_bus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .gpio_address (gpio_address),
    .gpio_data    (gpio_data),
    .gpio_rden    (gpio_rden),
    .gpio_wren    (gpio_wren),
    .gpio_clken   (gpio_clken),
    .gpio_q       (gpio_q)
  );

  // GPIO model: registered read, PDIR returns an externally set pin value.
  logic [WIDTH-1:0] mem [16];
  logic [WIDTH-1:0] pdir_val;

  always @(posedge clk) begin
    if (gpio_clken && gpio_wren) mem[gpio_address] <= gpio_data;
    if (gpio_clken && gpio_rden) gpio_q <= (gpio_address == 4'd4) ? pdir_val : mem[gpio_address];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic r, input logic we,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_i[n]                      = r;
    req_we_i[n]                   = we;
    req_addr_i[n*AW +: AW]        = a;
    req_wdata_i[n*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    rst         = 1'b1;
    req_i       = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    pdir_val    = 32'h0000_1234;

    // Reset state
    tick();
    tick();
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_ack",   64'(ack_o), 64'd0);
    chk("rst_err",   64'(err_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_strb",  64'({gpio_clken, gpio_wren, gpio_rden}), 64'd0);
    chk("rst_addr",  64'(gpio_address), 64'd0);
    chk("rst_data",  64'(gpio_data), 64'd0);
    rst = 1'b0;

    // Single write: req0 -> PDOR
    set_req(0, 1'b1, 1'b1, 4'd0, 32'hA5A5_0000);
    tick();
    chk("wr_issue_strb", 64'({gpio_clken, gpio_wren, gpio_rden}), 64'b110);
    chk("wr_issue_addr", 64'(gpio_address), 64'd0);
    chk("wr_issue_data", 64'(gpio_data), 64'hA5A5_0000);
    chk("wr_issue_ack",  64'(ack_o), 64'd0);
    chk("wr_issue_busy", 64'(busy_o), 64'd1);
    tick();
    chk("wr_resp_ack",  64'(ack_o), 64'b01);
    chk("wr_resp_err",  64'(err_o), 64'd0);
    chk("wr_resp_strb", 64'({gpio_clken, gpio_wren, gpio_rden}), 64'b000);
    req_i[0] = 1'b0;
    tick();
    chk("wr_idle_ack",  64'(ack_o), 64'd0);
    chk("wr_idle_busy", 64'(busy_o), 64'd0);

    // Single read: req1 <- PDIR
    set_req(1, 1'b1, 1'b0, 4'd4, 32'h0);
    tick();
    chk("rd_issue_strb", 64'({gpio_clken, gpio_wren, gpio_rden}), 64'b101);
    chk("rd_issue_addr", 64'(gpio_address), 64'd4);
    tick();
    chk("rd_resp_ack",   64'(ack_o), 64'b10);
    chk("rd_resp_rdata", 64'(rdata_o), 64'h0000_1234);
    chk("rd_resp_err",   64'(err_o), 64'd0);
    chk("rd_resp_rden",  64'(gpio_rden), 64'd0);
    req_i[1] = 1'b0;
    tick();
    chk("rd_idle_rdata", 64'(rdata_o), 64'd0);

    // Contention from reset: req0 writes PDDR, req1 reads PDDR back
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 4'd5, 32'h0000_00C3);
    set_req(1, 1'b1, 1'b0, 4'd5, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ct_issue_ack",  64'(ack_o), 64'd0);
      chk("ct_issue_wren", 64'(gpio_wren), (k % 2 == 0) ? 64'd1 : 64'd0);
      tick();
      chk("ct_resp_ack", 64'(ack_o), (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k % 2 == 1) chk("ct_resp_rdata", 64'(rdata_o), 64'h0000_00C3);
      tick();
      chk("ct_idle_ack", 64'(ack_o), 64'd0);
    end
    req_i = '0;
    tick();

    // Illegal accesses from req0: read PCOR, write PDIR, read unmapped 9
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       set_req(0, 1'b1, 1'b0, 4'd2, 32'h0);
        1:       set_req(0, 1'b1, 1'b1, 4'd4, 32'hFFFF_FFFF);
        default: set_req(0, 1'b1, 1'b0, 4'd9, 32'h0);
      endcase
      tick();
      chk("il_issue_busy", 64'(busy_o), 64'd1);
      chk("il_issue_strb", 64'({gpio_clken, gpio_wren, gpio_rden}), 64'b000);
      tick();
      chk("il_resp_ack",   64'(ack_o), 64'b01);
      chk("il_resp_err",   64'(err_o), 64'd1);
      chk("il_resp_rdata", 64'(rdata_o), 64'd0);
      chk("il_resp_strb",  64'({gpio_clken, gpio_wren, gpio_rden}), 64'b000);
      req_i[0] = 1'b0;
      tick();
    end

    // Command change during ISSUE: req1 writes PDDR
    set_req(1, 1'b1, 1'b1, 4'd5, 32'h1111_2222);
    tick();
    set_req(1, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
    req_i[0] = 1'b1;
    #1;
    chk("cc_issue_addr", 64'(gpio_address), 64'd5);
    chk("cc_issue_data", 64'(gpio_data), 64'h1111_2222);
    chk("cc_issue_wren", 64'(gpio_wren), 64'd1);
    tick();
    chk("cc_resp_ack",  64'(ack_o), 64'b10);
    chk("cc_resp_err",  64'(err_o), 64'd0);
    chk("cc_resp_addr", 64'(gpio_address), 64'd5);
    req_i = '0;
    tick();

    // Reset during ISSUE of a req0 write; pointer must return to 0
    set_req(0, 1'b1, 1'b1, 4'd1, 32'h0000_0F0F);
    tick();
    chk("rm_issue_wren", 64'(gpio_wren), 64'd1);
    rst = 1'b1;
    set_req(1, 1'b1, 1'b0, 4'd5, 32'h0);
    tick();
    chk("rm_rst_busy", 64'(busy_o), 64'd0);
    chk("rm_rst_ack",  64'(ack_o), 64'd0);
    chk("rm_rst_strb", 64'({gpio_clken, gpio_wren, gpio_rden}), 64'b000);
    rst = 1'b0;
    tick();
    chk("rm_next_strb", 64'({gpio_clken, gpio_wren, gpio_rden}), 64'b110);
    chk("rm_next_addr", 64'(gpio_address), 64'd1);
    tick();
    chk("rm_next_ack", 64'(ack_o), 64'b01);
    req_i = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
